// File: rtl/drive_pkg.sv
// Shared constants and FSM encoding for the drive update scheduler.
// Imported by drive_update_unit and drive_update_scheduler.
package drive_pkg;

  localparam int NUM_DRIVES = 4;
  localparam int LEVEL_W    = 8;
  localparam logic [7:0] LEVEL_RESET = 8'h80;
  localparam int STEP_SLOW  = 1;
  localparam int STEP_FAST  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/drive_update_unit.sv
// Shared combinational update: priority load/inc/dec with saturation.
// Ports: level, inc, dec, fast, setval, set_value in; level_nxt out.
module drive_update_unit #(
  parameter int LEVEL_W = drive_pkg::LEVEL_W
) (
  input  logic [LEVEL_W-1:0] level,
  input  logic               inc,
  input  logic               dec,
  input  logic               fast,
  input  logic               setval,
  input  logic [LEVEL_W-1:0] set_value,
  output logic [LEVEL_W-1:0] level_nxt
);
  import drive_pkg::*;

  logic [LEVEL_W-1:0] step;
  logic [LEVEL_W:0]   sum;
  logic               do_set;
  logic               do_inc;
  logic               do_dec;

  always_comb begin
    step = fast ? LEVEL_W'(STEP_FAST)
                : LEVEL_W'(STEP_SLOW);
    sum  = {1'b0, level} + {1'b0, step};
    // inc together with dec cancels out
    do_set = setval;
    do_inc = !setval && inc && !dec;
    do_dec = !setval && dec && !inc;
    level_nxt = level;
    unique case (1'b1)
      do_set: level_nxt = set_value;
      do_inc: level_nxt = sum[LEVEL_W] ? '1
                        : sum[LEVEL_W-1:0];
      do_dec: level_nxt = (level < step) ? '0
                        : level - step;
      default: level_nxt = level;
    endcase
  end

endmodule

// File: rtl/drive_update_scheduler.sv
// Prescaled round-robin scheduler updating drive levels via one shared unit.
// Ports: clk/rst, ena/prescale tick source, req_* per drive, levels out.
module drive_update_scheduler #(
  parameter int NUM_DRIVES = drive_pkg::NUM_DRIVES,
  parameter int LEVEL_W    = drive_pkg::LEVEL_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [7:0]                    prescale,
  input  logic [NUM_DRIVES-1:0]         req_inc,
  input  logic [NUM_DRIVES-1:0]         req_dec,
  input  logic [NUM_DRIVES-1:0]         req_fast,
  input  logic [NUM_DRIVES-1:0]         req_setval,
  input  logic [LEVEL_W-1:0]            set_value,
  output logic [NUM_DRIVES*LEVEL_W-1:0] levels,
  output logic [2*NUM_DRIVES-1:0]       levels_q,
  output logic [$clog2(NUM_DRIVES)-1:0] active_idx,
  output logic                          update_valid,
  output logic                          overrun
);
  import drive_pkg::*;

  localparam int IDX_W = $clog2(NUM_DRIVES);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_DRIVES - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pend_q, pend_d;
  logic               ovr_q, ovr_d;
  logic [LEVEL_W-1:0] lvl_q [NUM_DRIVES];
  logic [LEVEL_W-1:0] lvl_d [NUM_DRIVES];
  logic [LEVEL_W-1:0] lvl_nxt;
  logic               tick;

  drive_update_unit #(
    .LEVEL_W(LEVEL_W)
  ) u_unit (
    .level    (lvl_q[idx_q]),
    .inc      (req_inc[idx_q]),
    .dec      (req_dec[idx_q]),
    .fast     (req_fast[idx_q]),
    .setval   (req_setval[idx_q]),
    .set_value(set_value),
    .level_nxt(lvl_nxt)
  );

  always_comb begin
    tick  = ena && (cnt_q == prescale);
    cnt_d = cnt_q;
    if (ena) cnt_d = tick ? 8'd0 : cnt_q + 8'd1;

    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          // a pending tick restarts at once;
          // a tick landing now becomes the new pending
          idx_d = '0;
          if (pend_q) pend_d = tick;
          else if (!tick) state_d = IDLE;
        end else if (tick) begin
          if (pend_q) ovr_d = 1'b1;
          else pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NUM_DRIVES; i++)
      lvl_d[i] = lvl_q[i];
    if (state_q == SWEEP) lvl_d[idx_q] = lvl_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NUM_DRIVES; i++)
        lvl_q[i] <= LEVEL_W'(LEVEL_RESET);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < NUM_DRIVES; i++)
        lvl_q[i] <= lvl_d[i];
    end
  end

  always_comb begin
    levels   = '0;
    levels_q = '0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      levels[i*LEVEL_W +: LEVEL_W] = lvl_q[i];
      levels_q[2*i +: 2] = lvl_q[i][LEVEL_W-1 -: 2];
    end
  end

  assign update_valid = (state_q == SWEEP);
  assign active_idx   = update_valid ? idx_q : '0;
  assign overrun      = ovr_q;

endmodule
